// File: rtl/data_sram_resp_pkg.sv
// Shared constants, region select and byte-merge helper for the data SRAM responder.
package data_sram_resp_pkg;

  localparam logic [15:0] CONF_BASE   = 16'h1faf;
  localparam logic [15:0] LED_OFF     = 16'hf000;
  localparam logic [15:0] SCRATCH_OFF = 16'hf010;
  localparam logic [15:0] SWITCH_OFF  = 16'hf020;
  localparam logic [15:0] TIMER_OFF   = 16'he000;
  localparam int          NUM_LANES   = 4;

  typedef enum logic {REG_RAM, REG_CONF} region_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = wen[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// CPU data SRAM port: the CPU drives the request, the responder returns rdata.
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                  input  data_sram_rdata);
  modport slave  (input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                  output data_sram_rdata);
endinterface

// File: rtl/data_sram_resp_sp_ram_bytewe.sv
// Single-port RAM, synchronous read, per-byte-lane write, returns the pre-write word.
module sp_ram_bytewe #(
  parameter int AW        = 12,
  parameter int NUM_LANES = 4
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic [NUM_LANES-1:0]      wen,
  input  logic [AW-1:0]             addr,
  input  logic [NUM_LANES-1:0][7:0] wdata,
  output logic [NUM_LANES-1:0][7:0] rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [2**AW];
    logic [7:0] q;

    // Read and write share the edge, so q captures the old byte.
    always_ff @(posedge clk) begin
      if (en) begin
        if (wen[l]) mem[addr] <= wdata[l];
        q <= mem[addr];
      end
    end

    assign rdata[l] = q;
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: RAM plus LED/SCRATCH/SWITCH/TIMER config registers, 1-cycle reads.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          RAM_AW    = 12,
  parameter logic [15:0] CONF_BASE = data_sram_resp_pkg::CONF_BASE
) (
  input  logic         clk,
  input  logic         rst,
  data_sram_if.slave   bus,
  output logic [15:0]  led,
  input  logic [7:0]   switch
);

  region_e     region, region_q;
  logic        acc, wr;
  logic        hit_led, hit_scr, hit_tmr;
  logic [15:0] off;
  logic [31:0] conf_rd, conf_q, wmerge, ram_dout;
  logic [31:0] scratch, timer;
  logic [7:0]  sw_s1, sw_s2;
  logic        unused_addr;

  assign region  = (bus.data_sram_addr[31:16] == CONF_BASE) ? REG_CONF : REG_RAM;
  assign off     = {bus.data_sram_addr[15:2], 2'b00};
  assign acc     = bus.data_sram_en & ~rst;
  assign wr      = acc & (|bus.data_sram_wen);
  assign hit_led = (region == REG_CONF) && (off == LED_OFF);
  assign hit_scr = (region == REG_CONF) && (off == SCRATCH_OFF);
  assign hit_tmr = (region == REG_CONF) && (off == TIMER_OFF);
  assign unused_addr = ^bus.data_sram_addr[1:0];

  always_comb begin
    conf_rd = '0;
    case (off)
      LED_OFF:     conf_rd = {16'h0, led};
      SCRATCH_OFF: conf_rd = scratch;
      SWITCH_OFF:  conf_rd = {24'h0, sw_s2};
      TIMER_OFF:   conf_rd = timer;
      default:     conf_rd = '0;
    endcase
    wmerge = byte_merge(conf_rd, bus.data_sram_wdata, bus.data_sram_wen);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '0;
      scratch  <= '0;
      timer    <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      region_q <= REG_CONF;
      conf_q   <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      if (wr && hit_led) led     <= wmerge[15:0];
      if (wr && hit_scr) scratch <= wmerge;
      timer <= (wr && hit_tmr) ? wmerge : timer + 32'd1;
      // Both hold across idle cycles so rdata keeps its last value.
      if (acc) begin
        region_q <= region;
        conf_q   <= conf_rd;
      end
    end
  end

  sp_ram_bytewe #(.AW(RAM_AW), .NUM_LANES(NUM_LANES)) u_ram (
    .clk   (clk),
    .en    (acc && (region == REG_RAM)),
    .wen   (bus.data_sram_wen),
    .addr  (bus.data_sram_addr[RAM_AW+1:2]),
    .wdata (bus.data_sram_wdata),
    .rdata (ram_dout)
  );

  assign bus.data_sram_rdata = (region_q == REG_RAM) ? ram_dout : conf_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp; expected rdata goes through a scoreboard queue.
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  switch;
  logic [15:0] led;

  data_sram_if bus();

  data_sram_resp dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .led    (led),
    .switch (switch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One request per cycle, driven at the falling edge.
  task automatic req(input logic r, input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic chk, input logic [31:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    rst                 = r;
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    if (chk) begin
      e.exp  = exp;
      e.due  = cyc + 1;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check(e.name, bus.data_sram_rdata, e.exp);
    end
  end

  initial begin
    rst = 1'b1;
    switch = 8'h00;
    bus.data_sram_en = 1'b0; bus.data_sram_wen = '0;
    bus.data_sram_addr = '0; bus.data_sram_wdata = '0;

    req(1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0, "rst_rdata0");
    req(1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0, "rst_rdata1");
    check("rst_led", {16'h0, led}, 32'h0);

    // RAM full-word write, read, hold, byte-lane write
    req(0, 1, 4'hF, 32'h0000_0100, 32'h1234_5678, 0, 32'h0, "");
    req(0, 1, 4'h0, 32'h0000_0100, 32'h0,         1, 32'h1234_5678, "ram_rd");
    req(0, 0, 4'h0, 32'h0000_0100, 32'h0,         1, 32'h1234_5678, "idle_hold");
    req(0, 1, 4'h5, 32'h0000_0100, 32'hAABB_CCDD, 1, 32'h1234_5678, "ram_rbw");
    req(0, 1, 4'h0, 32'h0000_0100, 32'h0,         1, 32'h12BB_56DD, "ram_bytewe");

    // LED
    req(0, 1, 4'hF, 32'h1faf_f000, 32'h0000_BEEF, 1, 32'h0, "led_rbw");
    req(0, 1, 4'h0, 32'h1faf_f000, 32'h0,         1, 32'h0000_BEEF, "led_rd");
    check("led_port", {16'h0, led}, 32'h0000_BEEF);

    // SCRATCH with partial write
    req(0, 1, 4'hF, 32'h1faf_f010, 32'hDEAD_BEEF, 1, 32'h0, "scr_rbw");
    req(0, 1, 4'h8, 32'h1faf_f010, 32'h1100_0000, 1, 32'hDEAD_BEEF, "scr_rbw2");
    req(0, 1, 4'h0, 32'h1faf_f010, 32'h0,         1, 32'h11AD_BEEF, "scr_bytewe");

    // Unmapped config offset
    req(0, 1, 4'hF, 32'h1faf_f030, 32'hFFFF_FFFF, 1, 32'h0, "unmap_wr");
    req(0, 1, 4'h0, 32'h1faf_f030, 32'h0,         1, 32'h0, "unmap_rd");

    // TIMER load and wrap
    req(0, 1, 4'hF, 32'h1faf_e000, 32'hFFFF_FFFE, 0, 32'h0, "");
    req(0, 1, 4'h0, 32'h1faf_e000, 32'h0, 1, 32'hFFFF_FFFE, "tmr_rd0");
    req(0, 1, 4'h0, 32'h1faf_e000, 32'h0, 1, 32'hFFFF_FFFF, "tmr_rd1");
    req(0, 1, 4'h0, 32'h1faf_e000, 32'h0, 1, 32'h0000_0000, "tmr_wrap");

    // SWITCH through the synchroniser, then a write that must be ignored
    switch = 8'hA5;
    req(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0, "idle_hold2");
    req(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0, "idle_hold3");
    req(0, 1, 4'h0, 32'h1faf_f020, 32'h0,         1, 32'h0000_00A5, "sw_rd");
    req(0, 1, 4'hF, 32'h1faf_f020, 32'h1234_5678, 1, 32'h0000_00A5, "sw_wr");
    req(0, 1, 4'h0, 32'h1faf_f020, 32'h0,         1, 32'h0000_00A5, "sw_ro");

    // en=0 with write lanes set must not touch LED
    req(0, 0, 4'hF, 32'h1faf_f000, 32'h0, 1, 32'h0000_00A5, "noen_hold");
    req(0, 1, 4'h0, 32'h1faf_f000, 32'h0, 1, 32'h0000_BEEF, "noen_led");
    check("noen_led_port", {16'h0, led}, 32'h0000_BEEF);

    // RAM aliasing above RAM_AW
    req(0, 1, 4'hF, 32'h0000_4100, 32'hCAFE_F00D, 1, 32'h12BB_56DD, "alias_rbw");
    req(0, 1, 4'h0, 32'h0000_0100, 32'h0,         1, 32'hCAFE_F00D, "alias_rd");

    // Reset during a write
    req(0, 1, 4'hF, 32'h0000_0200, 32'h5555_5555, 0, 32'h0, "");
    req(0, 1, 4'h0, 32'h0000_0200, 32'h0,         1, 32'h5555_5555, "pre_rst_rd");
    req(1, 1, 4'hF, 32'h0000_0200, 32'h9999_9999, 1, 32'h0, "rst_drop_rdata");
    req(0, 1, 4'h0, 32'h1faf_e000, 32'h0,         1, 32'h0, "rst_timer");
    check("rst_led2", {16'h0, led}, 32'h0);
    req(0, 1, 4'h0, 32'h0000_0200, 32'h0,         1, 32'h5555_5555, "rst_nowrite");
    req(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, "");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter RAM_AW, default 12, word-address width of the internal RAM (4096 words, 16 KB).
REQ-002 Parameter CONF_BASE, default 16'h1faf, upper address half selecting the config-register region.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 data_sram_en  input  1  request valid this cycle.
REQ-006 data_sram_wen  input  4  byte write enables; 4'b0000 means read.
REQ-007 data_sram_addr  input  32  physical byte address, already kseg-masked by the CPU.
REQ-008 data_sram_wdata  input  32  write data, byte lanes matching wen.
REQ-009 data_sram_rdata  output  32  read data, valid the cycle after the request.
REQ-010 led  output  16  LED register contents.
REQ-011 switch  input  8  switch inputs, read-only.

Function
REQ-012 The block SHALL be the responder for the CPU data SRAM port; it SHALL never stall (no ready signal).
REQ-013 Region decode SHALL be: addr[31:16]==CONF_BASE selects config registers; any other address selects RAM, indexed by addr[RAM_AW+1:2] (upper bits ignored, aliasing permitted).
REQ-014 Config map: 0x…f000 LED (RW, low 16 bits), 0x…f010 SCRATCH (RW, 32 bits), 0x…f020 SWITCH (RO, zero-extended), 0x…e000 TIMER (RW, 32 bits).
REQ-015 Unmapped config offsets SHALL read 32'h0; writes to them and to SWITCH SHALL be ignored.
REQ-016 Read latency SHALL be exactly one cycle: request in cycle N with en=1, wen=0 -> rdata valid in cycle N+1.
REQ-017 data_sram_rdata SHALL hold its last value in every cycle following an en=0 cycle.
REQ-018 Writes SHALL update only the byte lanes with wen[i]=1, with the new value visible to a read issued the following cycle.
REQ-019 A write cycle (en=1, wen!=0) SHALL also update rdata in cycle N+1 with the pre-write word (read-before-write).
REQ-020 Back-to-back requests SHALL be accepted every cycle; a read of the address written in the previous cycle SHALL return the written data.
REQ-021 TIMER SHALL increment by 1 every cycle, wrapping 32'hffffffff -> 0.
REQ-022 A TIMER write in cycle N SHALL load the byte-merged value, with no increment that cycle; incrementing resumes in N+1.
REQ-023 A TIMER read in cycle N SHALL return the value TIMER held during cycle N.
REQ-024 led SHALL be driven directly from the LED register with no extra latency beyond the write edge.
REQ-025 switch SHALL be sampled through a two-flop synchroniser; reads return the synchronised value.
REQ-026 Requests with en=0 SHALL have no side effects regardless of wen, addr, or wdata.

Reset
REQ-027 With rst=1 at a rising edge: rdata=0, LED=0, SCRATCH=0, TIMER=0, synchroniser flops=0.
REQ-028 RAM contents SHALL NOT be cleared by reset; a request presented while rst=1 SHALL be dropped (no write, rdata=0 in the next cycle).
REQ-029 The first request accepted after rst deasserts SHALL follow REQ-016 with no additional latency.

Structure
REQ-030 A shared package SHALL hold CONF_BASE, register offsets (LED_OFF, SCRATCH_OFF, SWITCH_OFF, TIMER_OFF), and the region-select enum {REG_RAM, REG_CONF}.
REQ-031 The RAM SHALL be a sub-module sp_ram_bytewe: single port, synchronous read, 4-lane byte write, read-before-write.
REQ-032 The top level SHALL register the region select and the config read value so the output mux is aligned with the RAM's one-cycle read.

Verification
REQ-033 Write 0x12345678 (wen=1111) to 0x00000100, then read 0x00000100 -> rdata=0x12345678 one cycle after the read.
REQ-034 Write 0xAABBCCDD with wen=0101 over a word holding 0x12345678, then read -> 0x12BB56DD.
REQ-035 Write 0x0000BEEF to 0x1faff000 -> led=0xBEEF after the edge; a read returns 0x0000BEEF.
REQ-036 Write 0xFFFFFFFE to TIMER, then read on each of the next 3 cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-037 Hold switch=0xA5, wait 2 cycles, read 0x1faff020 -> 0x000000A5; a write there leaves the read value unchanged.
REQ-038 Assert rst during a write to 0x00000200 -> word unchanged, rdata=0, led=0, TIMER=0.
